// File: rtl/oven_sched_pkg.sv
// oven_sched_pkg: shared state encoding, parameter defaults and a small
// round-robin index helper for the oven order scheduler.
package oven_sched_pkg;

  // Default configuration of the scheduler.
  localparam int NUM_REQ_DEF = 4;
  localparam int CT_W_DEF    = 8;

  // Scheduler FSM encoding (3 bits).
  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_START       = 3'd1,
    S_WAIT_LOAD   = 3'd2,
    S_COOK        = 3'd3,
    S_WAIT_UNLOAD = 3'd4
  } sched_state_t;

  // Station index reached by stepping 'offset' places from 'base' around a
  // ring of 'n' stations. Both inputs are below n, so a single conditional
  // subtract replaces a modulo that would not be cheap for non-power-of-two n.
  function automatic int rr_index(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/cook_timer.sv
// cook_timer: per-order countdown. Loads the latched cook time, counts down
// while enabled and nonzero, and flags zero.
module cook_timer #(
  parameter int CT_W = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [CT_W-1:0] i_value,
  input  logic            i_en,
  output logic            o_zero
);

  logic [CT_W-1:0] r_count;

  // Countdown register: load wins, otherwise decrement down to zero and stop.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/oven_order_scheduler.sv
// oven_order_scheduler: shares one auto_oven_style cooker between NUM_REQ
// stations. Round-robin arbitration while the oven is idle, then follows the
// oven through start / load / cook / unload and reports grant and served.
// Optional feature macro: COOK_TIMER_EN -- when defined, an internal per-order
// countdown (cook_timer) decides cook completion and i_ext_done is ignored;
// when undefined, i_ext_done gated to S_COOK decides it and i_cook_time is
// ignored.
module oven_order_scheduler
  import oven_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int CT_W    = CT_W_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ*CT_W-1:0] i_cook_time,
  input  logic                    i_ext_done,
  input  logic                    i_oven_load,
  input  logic                    i_oven_heat,
  input  logic                    i_oven_unload,
  output logic                    o_oven_start,
  output logic                    o_oven_done,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_served,
  output logic                    o_busy,
  output logic [ID_W-1:0]         o_cur_id
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_cur_id;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_served;

  logic               w_win_found;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_arb_ok;
  logic               w_cook_done;
  logic               w_timer_load;

  // Round-robin search: first requesting station at or after r_rr_ptr.
  // NOTE: every signal written here gets a default before the case/loop
  // logic; a path that leaves one unassigned would infer a latch.
  always_comb begin
    int idx;
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = rr_index(int'(r_rr_ptr), i, NUM_REQ);
      if (!w_win_found && i_req[idx]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'(idx);
      end
    end
  end

  // Pointer moves one past the winner, wrapping at the last station.
  assign w_next_ptr = (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : (w_win_id + ID_W'(1));

  // A new order is accepted only while the oven is fully idle; this also keeps
  // the block from granting into an oven cycle left running across a reset.
  assign w_arb_ok = (r_state == S_IDLE) && w_win_found && !i_oven_heat && !i_oven_unload;

`ifdef COOK_TIMER_EN
  logic [CT_W-1:0] r_ct_lat;
  logic            w_timer_zero;
  logic            w_unused_ext;

  // Latch the winner's cook time at grant; later changes on its slice are ignored.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ct_lat <= '0;
    end else if (w_arb_ok) begin
      r_ct_lat <= i_cook_time[int'(w_win_id) * CT_W +: CT_W];
    end
  end

  cook_timer #(
    .CT_W (CT_W)
  ) u_cook_timer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_timer_load),
    .i_value (r_ct_lat),
    .i_en    (r_state == S_COOK),
    .o_zero  (w_timer_zero)
  );

  assign w_cook_done  = w_timer_zero;
  assign w_unused_ext = i_ext_done;
`else
  logic w_unused_ct;

  assign w_cook_done = i_ext_done;
  assign w_unused_ct = ^{i_cook_time, w_timer_load};
`endif

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the oven handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    o_oven_start = 1'b0;
    o_oven_done  = 1'b0;
    w_timer_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_ok) w_state_nxt = S_START;
      end
      S_START: begin
        // Held until preheat is visible; preheat length is unbounded.
        o_oven_start = 1'b1;
        if (i_oven_heat) w_state_nxt = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        if (i_oven_load) begin
          w_timer_load = 1'b1;
          w_state_nxt  = S_COOK;
        end
      end
      S_COOK: begin
        o_oven_done = w_cook_done;
        if (w_cook_done) w_state_nxt = S_WAIT_UNLOAD;
      end
      S_WAIT_UNLOAD: begin
        // Keep done asserted until the oven acknowledges by unloading.
        o_oven_done = 1'b1;
        if (i_oven_unload) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered grant/served pulses, order id and round-robin pointer.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_grant  <= '0;
      r_served <= '0;
      r_cur_id <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_grant  <= '0;
      r_served <= '0;
      if (w_arb_ok) begin
        r_grant[w_win_id] <= 1'b1;
        r_cur_id          <= w_win_id;
        r_rr_ptr          <= w_next_ptr;
      end
      if ((r_state == S_WAIT_UNLOAD) && i_oven_unload) begin
        r_served[r_cur_id] <= 1'b1;
      end
    end
  end

  assign o_grant  = r_grant;
  assign o_served = r_served;
  assign o_cur_id = r_cur_id;
  assign o_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_oven_order_scheduler.sv
// tb_oven_order_scheduler: directed bench for oven_order_scheduler with a
// behavioural auto_oven_style model (IDLE -> PREHEAT -> LOAD -> COOK -> UNLOAD).
// The model's cook sensor drives ext_done after the order's cook time so the
// same expected timing holds with and without COOK_TIMER_EN.
module tb_oven_order_scheduler;

  localparam int PREHEAT_CYC = 3;

  typedef enum logic [2:0] {O_IDLE, O_PREHEAT, O_LOAD, O_COOK, O_UNLOAD} oven_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] cook_time;
  logic        ext_done;
  logic        oven_load, oven_heat, oven_unload;
  logic        o_oven_start, o_oven_done, o_busy;
  logic [3:0]  o_grant, o_served;
  logic [1:0]  o_cur_id;

  oven_t ov_st     = O_IDLE;
  int    ov_cnt    = 0;
  int    sensor_n  = 0;
  logic  ext_force = 1'b0;
  logic  ov_abort  = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int n_grants = 0;
  int n_served = 0;
  int bad_grant = 0;
  int bad_served = 0;
  logic outstanding = 1'b0;
  logic prev_served = 1'b0;
  int last_ts = -100;

  always #5 clk = ~clk;

  oven_order_scheduler #(
    .NUM_REQ (4),
    .CT_W    (8)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req         (req),
    .i_cook_time   (cook_time),
    .i_ext_done    (ext_done),
    .i_oven_load   (oven_load),
    .i_oven_heat   (oven_heat),
    .i_oven_unload (oven_unload),
    .o_oven_start  (o_oven_start),
    .o_oven_done   (o_oven_done),
    .o_grant       (o_grant),
    .o_served      (o_served),
    .o_busy        (o_busy),
    .o_cur_id      (o_cur_id)
  );

  // Oven model: no reset; ov_abort is a manual override that ends a cook.
  always @(posedge clk) begin
    case (ov_st)
      O_IDLE:    if (o_oven_start) begin ov_st <= O_PREHEAT; ov_cnt <= 0; end
      O_PREHEAT: if (ov_cnt == PREHEAT_CYC - 1) ov_st <= O_LOAD; else ov_cnt <= ov_cnt + 1;
      O_LOAD:    begin ov_st <= O_COOK; ov_cnt <= 0; end
      O_COOK:    if (o_oven_done || ov_abort) ov_st <= O_UNLOAD; else ov_cnt <= ov_cnt + 1;
      default:   ov_st <= O_IDLE;
    endcase
  end

  assign oven_heat   = (ov_st == O_PREHEAT) || (ov_st == O_LOAD) || (ov_st == O_COOK);
  assign oven_load   = (ov_st == O_LOAD);
  assign oven_unload = (ov_st == O_UNLOAD);
  assign ext_done    = ext_force || ((ov_st == O_COOK) && (ov_cnt == sensor_n));

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor: one order outstanding at a time, one-hot grants,
  // single-cycle served pulses that match an outstanding order.
  always @(negedge clk) begin
    prev_served <= |o_served;
    if (rst) begin
      outstanding <= 1'b0;
    end else begin
      if (|o_grant) begin
        n_grants <= n_grants + 1;
        if (outstanding || !$onehot(o_grant)) bad_grant <= bad_grant + 1;
        outstanding <= 1'b1;
      end
      if (|o_served) begin
        n_served <= n_served + 1;
        if (!outstanding || prev_served || !$onehot(o_served)) bad_served <= bad_served + 1;
        outstanding <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_ct(input int id, input int n);
    cook_time[id*8 +: 8] = 8'(n);
  endtask

  // Follows one order from grant to served, checking cycle-exact handshakes.
  task automatic serve_order(input logic [3:0] exp_vec, input int exp_id, input int n,
                             input bit drop_req, input bit poke_ext, input int exp_gap,
                             output int tg);
    int  tl, td, k;
    bit  seen;
    logic early;
    sensor_n = n;
    seen = 1'b0;
    tg = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = |o_grant;
    end
    check("grant_seen", 32'(seen), 1);
    if (!seen) return;
    tg = cyc;
    check("grant_vec", o_grant, exp_vec);
    check("cur_id", o_cur_id, exp_id);
    check("busy_at_grant", o_busy, 1);
    check("start_at_grant", o_oven_start, 1);
    check("done_at_grant", o_oven_done, 0);
    if (exp_gap >= 0) check("grant_gap", tg - last_ts, exp_gap);
    if (drop_req) req[exp_id] = 1'b0;
    ext_force = poke_ext;
    early = o_oven_done;
    @(negedge clk);
    check("grant_pulse", o_grant, 0);
    check("start_hold", o_oven_start, 1);
    early = early | o_oven_done;
    @(negedge clk);
    check("start_drop", o_oven_start, 0);
    k = 0;
    while (!oven_load && k < 20) begin
      early = early | o_oven_done;
      @(negedge clk);
      k++;
    end
    early = early | o_oven_done;
    tl = cyc;
    check("load_seen", oven_load, 1);
    check("load_latency", tl - tg, 4);
    check("no_early_done", early, 0);
    ext_force = 1'b0;
    for (int i = 0; i < n + 10 && !o_oven_done; i++) @(negedge clk);
    td = cyc;
    check("done_seen", o_oven_done, 1);
    check("cook_len", td - tl, n + 1);
    @(negedge clk);
    check("unload_after_done", oven_unload, 1);
    check("done_hold", o_oven_done, 1);
    check("busy_in_unload", o_busy, 1);
    check("served_not_early", o_served, 0);
    @(negedge clk);
    check("served_vec", o_served, exp_vec);
    check("busy_after_served", o_busy, 0);
    check("done_clear", o_oven_done, 0);
    last_ts = cyc;
  endtask

  initial begin
    int tg, tu, g0, s0;
    rst = 1'b1;
    req = '0;
    cook_time = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_grant", o_grant, 0);
    check("rst_served", o_served, 0);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_oven_start, 0);
    check("rst_done", o_oven_done, 0);
    check("rst_cur_id", o_cur_id, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_req_busy", o_busy, 0);

    // Single request with cook time 5; station drops req right after grant.
    set_ct(1, 5);
    req = 4'b0010;
    serve_order(4'b0010, 1, 5, 1'b1, 1'b1, -1, tg);
    repeat (6) @(negedge clk);
    check("single_grant_count", n_grants, 1);

    // Contention from a fresh pointer: 0,1,2,3,0 with back-to-back grants.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ct(0, 3); set_ct(1, 0); set_ct(2, 2); set_ct(3, 1);
    req = 4'b1111;
    serve_order(4'b0001, 0, 3, 1'b0, 1'b0, -1, tg);
    serve_order(4'b0010, 1, 0, 1'b0, 1'b0, 1, tg);
    serve_order(4'b0100, 2, 2, 1'b0, 1'b0, 1, tg);
    serve_order(4'b1000, 3, 1, 1'b0, 1'b0, 1, tg);
    serve_order(4'b0001, 0, 3, 1'b0, 1'b0, 1, tg);
    req = '0;

    // Pointer wrap: serve 3, then 1001 must go to 0 before 3.
    set_ct(0, 2);
    req = 4'b1000;
    serve_order(4'b1000, 3, 1, 1'b1, 1'b0, -1, tg);
    req = 4'b1001;
    serve_order(4'b0001, 0, 2, 1'b1, 1'b1, 1, tg);
    serve_order(4'b1000, 3, 1, 1'b1, 1'b0, 1, tg);

    // Reset while the oven cooks: order lost, no grant until the oven idles.
    set_ct(0, 40);
    sensor_n = 1000;
    req = 4'b0001;
    for (int i = 0; i < 30 && ov_st != O_COOK; i++) @(negedge clk);
    check("rst_test_in_cook", ov_st == O_COOK, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_oven_done, 0);
    check("midrst_start", o_oven_start, 0);
    check("midrst_grant", o_grant, 0);
    check("midrst_served", o_served, 0);
    @(negedge clk);
    rst = 1'b0;
    set_ct(0, 2);
    g0 = n_grants;
    repeat (10) @(negedge clk);
    check("midrst_no_grant", n_grants - g0, 0);
    check("midrst_idle", o_busy, 0);
    ov_abort = 1'b1;
    @(negedge clk);
    ov_abort = 1'b0;
    tu = cyc;
    check("midrst_oven_unload", oven_unload, 1);
    s0 = n_served;
    serve_order(4'b0001, 0, 2, 1'b1, 1'b0, -1, tg);
    check("midrst_regrant_lat", tg - tu, 2);
    @(negedge clk);
    check("midrst_lost_order", n_served - s0, 1);

    repeat (3) @(negedge clk);
    check("total_grants", n_grants, 11);
    check("total_served", n_served, 10);
    check("bad_grant", bad_grant, 0);
    check("bad_served", bad_served, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the directed run is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
